capture_sequencer: RTL

//  Sequences one acquisition burst: enables the ADC reader, buffers N 12-bit samples, then streams them

---
 rtl/capture_sequencer_pkg.sv | 20 ++
 rtl/capture_sequencer_buffer.sv | 43 ++++
 rtl/capture_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/capture_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// capture_sequencer_pkg
// Shared definitions for the acquisition burst sequencer: default datapath
// sizes and the sequencer state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package capture_sequencer_pkg;

    localparam int CS_DATA_W = 12;  // ADC sample width
    localparam int CS_DEPTH  = 12;  // buffer entries = longest burst
    localparam int CS_CNT_W  = 4;   // count/pointer width, 2**CS_CNT_W > CS_DEPTH

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        WAIT_TX
    } state_t;

endpackage

// File: rtl/capture_sequencer_buffer.sv
// -----------------------------------------------------------------------------
// capture_sequencer_buffer (sample_buffer)
// DEPTH x DATA_W register array holding one burst of samples.
// Ports:
//   clk      in   1       system clock
//   i_we     in   1       write enable
//   i_waddr  in   AW      write address
//   i_wdata  in   DATA_W  write data
//   i_raddr  in   AW      read address (asynchronous read)
//   o_rdata  out  DATA_W  read data; 0 for addresses beyond DEPTH-1
// -----------------------------------------------------------------------------
module capture_sequencer_buffer #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 12,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: storage arrays carry no reset; every entry is written before it is
    // read in a burst, and a reset branch would turn the array into flops with
    // a reset tree instead of plain storage. Sequential writes use <= so all
    // readers in the same edge see the pre-edge value.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // The sequencer may present DEPTH as a look-ahead address after the final
    // transfer; that value is never consumed, so return 0 instead of X.
    assign o_rdata = (i_raddr <= LAST_ADDR) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/capture_sequencer.sv
// -----------------------------------------------------------------------------
// capture_sequencer
// Runs one acquisition burst: enables the ADC reader, buffers up to DEPTH
// samples, then hands them oldest-first to the serial writer one frame at a
// time, optionally spacing frames by GAP_CYCLES idle clocks.
// Ports:
//   clk          in   1       system clock
//   rst          in   1       synchronous active-low reset
//   start        in   1       pulse: begin burst (only accepted in IDLE)
//   abort        in   1       level: back to IDLE next cycle, no done
//   num_samples  in   CNT_W   requested burst length (clamped to DEPTH)
//   adc_valid    in   1       strobe: adc_data holds a fresh sample
//   adc_data     in   DATA_W  sample from ADC reader
//   adc_enable   out  1       run ADC reader
//   tx_start     out  1       pulse: writer loads tx_data
//   tx_data      out  DATA_W  sample for writer, held until next tx_start
//   tx_done      in   1       pulse: writer finished frame
//   busy         out  1       sequencer not idle
//   done         out  1       pulse: burst fully transmitted
//   dropped      out  1       sticky: strobe arrived while reader disabled
//   collected    out  CNT_W   samples buffered this burst
//   transmitted  out  CNT_W   samples sent this burst
// -----------------------------------------------------------------------------
module capture_sequencer
    import capture_sequencer_pkg::*;
#(
    parameter int DATA_W     = CS_DATA_W,
    parameter int DEPTH      = CS_DEPTH,
    parameter int CNT_W      = CS_CNT_W,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    output logic              adc_enable,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done,
    output logic              busy,
    output logic              done,
    output logic              dropped,
    output logic [CNT_W-1:0]  collected,
    output logic [CNT_W-1:0]  transmitted
);

    localparam int               GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_num_len;
    logic [CNT_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_collected;
    logic [CNT_W-1:0]    r_transmitted;
    logic                r_adc_enable;
    logic                r_tx_start;
    logic [DATA_W-1:0]   r_tx_data;
    logic                r_done;
    logic                r_dropped;
    logic                r_gap_active;
    logic [GAP_W-1:0]    r_gap_cnt;

    logic [CNT_W-1:0]    w_num_len;
    logic [CNT_W-1:0]    w_raddr;
    logic [DATA_W-1:0]   w_rdata;
    logic [DATA_W-1:0]   w_first;
    logic                w_we;

    assign w_num_len = (num_samples > DEPTH_C) ? DEPTH_C : num_samples;
    assign w_we      = rst && !abort && (r_state == COLLECT) && adc_valid;

    // With no gap the next entry is loaded on the same edge that retires the
    // current one, so the read port looks one entry ahead while waiting.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_raddr = r_rd_ptr;
        if (r_state == WAIT_TX && !r_gap_active) begin
            w_raddr = r_rd_ptr + ONE_C;
        end
    end

    // For a one-sample burst, buf[0] is written on the same edge that loads
    // the first frame, so forward the incoming sample.
    assign w_first = (r_wr_ptr == '0) ? adc_data : w_rdata;

    capture_sequencer_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (CNT_W)
    ) u_buffer (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (adc_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_num_len     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_collected   <= '0;
            r_transmitted <= '0;
            r_adc_enable  <= 1'b0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= '0;
            r_done        <= 1'b0;
            r_dropped     <= 1'b0;
            r_gap_active  <= 1'b0;
            r_gap_cnt     <= '0;
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;

            // Late or stray strobe while the reader is off; a start below
            // overrides this by clearing the flag.
            if (adc_valid && r_state != COLLECT && !r_adc_enable) begin
                r_dropped <= 1'b1;
            end

            if (abort) begin
                // Counters and pointers are left as-is for debug.
                r_state      <= IDLE;
                r_adc_enable <= 1'b0;
                r_gap_active <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_dropped <= 1'b0;
                            r_num_len <= w_num_len;
                            if (w_num_len == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state       <= COLLECT;
                                r_adc_enable  <= 1'b1;
                                r_wr_ptr      <= '0;
                                r_rd_ptr      <= '0;
                                r_collected   <= '0;
                                r_transmitted <= '0;
                                r_gap_active  <= 1'b0;
                            end
                        end
                    end

                    COLLECT: begin
                        if (adc_valid) begin
                            r_wr_ptr    <= r_wr_ptr + ONE_C;
                            r_collected <= r_collected + ONE_C;
                            if (r_collected == r_num_len - ONE_C) begin
                                r_state      <= DRAIN;
                                r_adc_enable <= 1'b0;
                                r_tx_start   <= 1'b1;
                                r_tx_data    <= w_first;
                            end
                        end
                    end

                    // The first frame's tx_start is visible during this state.
                    DRAIN: begin
                        r_state <= WAIT_TX;
                    end

                    WAIT_TX: begin
                        if (r_gap_active) begin
                            if (r_gap_cnt == GAP_W'(1)) begin
                                r_gap_active <= 1'b0;
                                r_tx_start   <= 1'b1;
                                r_tx_data    <= w_rdata;
                            end else begin
                                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                            end
                        end else if (tx_done) begin
                            r_transmitted <= r_transmitted + ONE_C;
                            r_rd_ptr      <= r_rd_ptr + ONE_C;
                            if (r_transmitted == r_num_len - ONE_C) begin
                                r_done  <= 1'b1;
                                r_state <= IDLE;
                            end else if (GAP_CYCLES == 0) begin
                                r_tx_start <= 1'b1;
                                r_tx_data  <= w_rdata;
                            end else begin
                                r_gap_active <= 1'b1;
                                r_gap_cnt    <= GAP_W'(GAP_CYCLES);
                            end
                        end
                    end

                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign adc_enable  = r_adc_enable;
    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign dropped     = r_dropped;
    assign collected   = r_collected;
    assign transmitted = r_transmitted;

endmodule
